// File: rtl/i2c_slave_uart_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_uart_if
//  Description : Bus bundle for i2c_slave_uart.
//                CPU side : sel, rnw, address, datain, dataout
//                I2C side : scl_in, sda_in (raw pins), sda_oe (open-drain
//                           pull-low enable)
//                Misc     : rx_irq
//                master modport = CPU/pin side, slave modport = the block.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_slave_uart_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  sel;
  logic                  rnw;
  logic                  address;
  logic [DATA_WIDTH-1:0] datain;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic                  rx_irq;

  modport master (
    output sel, rnw, address, datain, scl_in, sda_in,
    input  dataout, sda_oe, rx_irq
  );

  modport slave (
    input  sel, rnw, address, datain, scl_in, sda_in,
    output dataout, sda_oe, rx_irq
  );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_uart.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_uart
//  Description : Byte-wide bus-mapped serial port acting as a 7-bit I2C
//                slave. Master writes land in the RX FIFO for the CPU; CPU
//                writes fill the TX FIFO that the master reads back.
//  Ports       : clk, reset (async, active high)
//                bus.sel/rnw/address/datain  CPU access (address 0 = DATA,
//                                            1 = STATUS)
//                bus.dataout                 combinational read data
//                bus.scl_in/sda_in           raw I2C pins (oversampled)
//                bus.sda_oe                  1 = pull SDA low
//                bus.rx_irq                  registered rx_not_empty
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_slave_uart #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [6:0] I2C_ADDR   = 7'h42,
  parameter int         FIFO_LOG2  = 3
) (
  input  logic             clk,
  input  logic             reset,
  i2c_slave_uart_if.slave  bus
);
  localparam int                   DEPTH      = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_LOG2:0]   CNT_ONE    = (FIFO_LOG2 + 1)'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE    = FIFO_LOG2'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  // ---------------- pin synchronisers and edge detection ----------------
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_in; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= bus.sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  // ---------------- state ----------------
  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   phase;    // second half of a two-step ACK slot
  logic                   rw;
  logic                   ack_ok;
  logic                   sda_oe_r;
  logic                   rx_irq_r;
  logic                   rx_ovf, tx_unf;

  logic [7:0]             rx_mem [DEPTH];
  logic [7:0]             tx_mem [DEPTH];
  logic [FIFO_LOG2-1:0]   rx_wr, rx_rd, tx_wr, tx_rd;
  logic [FIFO_LOG2:0]     rx_count, tx_count;

  // ---------------- CPU decode ----------------
  logic cpu_rd_data, cpu_rd_stat, cpu_wr_data;
  assign cpu_rd_data = bus.sel &  bus.rnw & ~bus.address;
  assign cpu_rd_stat = bus.sel &  bus.rnw &  bus.address;
  assign cpu_wr_data = bus.sel & ~bus.rnw & ~bus.address;

  logic rx_empty, rx_full, tx_empty, tx_full;
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_COUNT);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL_COUNT);

  logic rx_pop, tx_push;
  assign rx_pop  = cpu_rd_data & ~rx_empty;
  assign tx_push = cpu_wr_data & ~tx_full;

  // ---------------- I2C-side FIFO strobes ----------------
  logic       no_cond;
  logic [7:0] byte_in;
  logic       wr_done, rx_room, rx_push, ovf_set;
  logic       load_evt, tx_pop, unf_set;
  logic [7:0] load_byte;

  assign no_cond  = ~start_det & ~stop_det;
  assign byte_in  = {shift[6:0], sda_s2};
  assign wr_done  = no_cond & (state == WR_BYTE) & scl_rise & (bit_cnt == 4'd7);
  // A CPU pop on the same edge frees the slot a full FIFO needs.
  assign rx_room  = ~rx_full | rx_pop;
  assign rx_push  = wr_done & rx_room;
  assign ovf_set  = wr_done & ~rx_room;
  assign load_evt = no_cond & scl_fall & phase &
                    (((state == ADDR_ACK) & rw) | (state == RD_ACK));
  assign tx_pop   = load_evt & ~tx_empty;
  assign unf_set  = load_evt & tx_empty;
  assign load_byte = tx_empty ? 8'hFF : tx_mem[tx_rd];

  // ---------------- FIFOs ----------------
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= byte_in;
    if (tx_push) tx_mem[tx_wr] <= bus.datain[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
      tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: ;
      endcase
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // ---------------- sticky status and irq ----------------
  // A STATUS read clears the sticky bits unless a new event lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ovf   <= 1'b0;
      tx_unf   <= 1'b0;
      rx_irq_r <= 1'b0;
    end else begin
      rx_ovf   <= ovf_set | (rx_ovf & ~cpu_rd_stat);
      tx_unf   <= unf_set | (tx_unf & ~cpu_rd_stat);
      rx_irq_r <= ~rx_empty;
    end
  end

  // ---------------- protocol FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      phase    <= 1'b0;
      rw       <= 1'b0;
      ack_ok   <= 1'b0;
      sda_oe_r <= 1'b0;
    end else if (start_det) begin
      state    <= ADDR;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      sda_oe_r <= 1'b0;
    end else if (stop_det) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      sda_oe_r <= 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift <= byte_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              rw      <= sda_s2;
              phase   <= 1'b0;
              state   <= (byte_in[7:1] == I2C_ADDR) ? ADDR_ACK : IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        // First SCL fall drives ACK; the second ends the ACK slot.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_r <= 1'b1;
              phase    <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              if (rw) begin
                shift    <= load_byte;
                sda_oe_r <= ~load_byte[7];
                state    <= RD_BYTE;
              end else begin
                sda_oe_r <= 1'b0;
                state    <= WR_BYTE;
              end
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift <= byte_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              ack_ok  <= rx_room;
              phase   <= 1'b0;
              state   <= WR_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_r <= ack_ok;
              phase    <= 1'b1;
            end else begin
              sda_oe_r <= 1'b0;
              phase    <= 1'b0;
              state    <= WR_BYTE;
            end
          end
        end
        // bit_cnt counts rises; each following fall presents the next bit.
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_r <= 1'b0;
              phase    <= 1'b0;
              state    <= RD_ACK;
            end else begin
              shift    <= {shift[6:0], 1'b0};
              sda_oe_r <= ~shift[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && !phase) begin
            if (sda_s2) state <= IGNORE;
            else        phase <= 1'b1;
          end else if (scl_fall && phase) begin
            shift    <= load_byte;
            sda_oe_r <= ~load_byte[7];
            bit_cnt  <= '0;
            phase    <= 1'b0;
            state    <= RD_BYTE;
          end
        end
        default: ;  // IDLE and IGNORE wait for START/STOP
      endcase
    end
  end

  // ---------------- outputs ----------------
  logic       busy;
  logic [7:0] status;
  logic [7:0] rd_byte;

  assign busy   = (state == ADDR_ACK) | (state == WR_BYTE) | (state == WR_ACK) |
                  (state == RD_BYTE)  | (state == RD_ACK);
  assign status = {3'b000, busy, tx_unf, rx_ovf, ~tx_full, ~rx_empty};

  always_comb begin
    rd_byte = 8'h00;
    if (bus.sel && bus.rnw) begin
      if (bus.address)    rd_byte = status;
      else if (!rx_empty) rd_byte = rx_mem[rx_rd];
    end
  end

  assign bus.dataout = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
  assign bus.sda_oe  = sda_oe_r;
  assign bus.rx_irq  = rx_irq_r;

  logic unused_datain;
  assign unused_datain = &{1'b0, bus.datain[DATA_WIDTH-1:8]};
endmodule
`default_nettype wire

// File: doc/i2c_slave_uart.md
Name: i2c_slave_uart

Overview:
- Byte-wide, bus-mapped serial port. The CPU talks to it over the on-chip bus; an external I2C master talks to it over SDA/SCL.
- Acts as an I2C slave (7-bit address) with an RX FIFO (master writes to CPU) and a TX FIFO (CPU writes to master).
- Sits directly on the SoC bus behind the 0xfe page decode. Its dataout feeds the CPU read mux; its datain comes from the pipelined bus.
- All logic runs on the single system clock; SCL/SDA are oversampled.

Parameters:
- DATA_WIDTH, 16, CPU bus width. Only bits [7:0] carry data; upper read bits are zero.
- I2C_ADDR, 7'h42, slave address this block answers to.
- FIFO_LOG2, 3, log2 of the depth of each FIFO (default 8 entries).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sel  in  1  chip select from the page decode
- rnw  in  1  1 = CPU read, 0 = CPU write
- address  in  1  0 = DATA register, 1 = STATUS register
- datain  in  DATA_WIDTH  CPU write data; bits [7:0] used
- dataout  out  DATA_WIDTH  combinational read data
- scl_in  in  1  raw SCL pin
- sda_in  in  1  raw SDA pin
- sda_oe  out  1  1 = drive SDA low; pin is open-drain
- rx_irq  out  1  registered copy of rx_not_empty

Behaviour:
- Reset (asynchronous): FIFOs empty, FSM in IDLE, sda_oe=0, rx_irq=0, overflow=0, underflow=0.
- CPU bus. Side effects occur only on a clk edge with sel=1.
  - Write DATA: push datain[7:0] to TX. If TX is full, the write is dropped.
  - Read DATA: dataout = {0, RX head}. Pop on the same edge. Reading an empty RX returns 0 and pops nothing.
  - Read STATUS: bit0 rx_not_empty, bit1 tx_not_full, bit2 rx_overflow, bit3 tx_underflow, bit4 busy (addressed transfer in progress).
  - A STATUS read clears bits 2 and 3 on that edge. A new event on the same edge wins; the bit stays set.
  - Writes to STATUS are ignored. With sel=0, dataout=0.
  - Push and pop on the same edge on the same FIFO: both take effect and the count is unchanged.
- FIFO: circular, FIFO_LOG2-bit pointers plus a count of FIFO_LOG2+1 bits. Pointers wrap modulo depth.
- I2C sampling:
  - 2-flop synchroniser on SCL and SDA, then edge detectors.
  - Requires f_clk >= 16 × f_SCL.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - START or STOP in any state aborts the transfer and releases sda_oe. START also resets the bit counter and goes to ADDR.
  - A partially received byte is discarded on abort.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - Data is sampled on synchronised SCL rise. sda_oe changes only on synchronised SCL fall.
  - ADDR: shift 8 bits, MSB first.
    - If addr[7:1]==I2C_ADDR, go to ADDR_ACK and drive ACK (sda_oe=1) for one SCL cycle.
    - Otherwise go to IGNORE until the next START/STOP.
  - After ADDR_ACK: R/W bit=0 goes to WR_BYTE; R/W bit=1 loads the TX head into the shift register and goes to RD_BYTE.
  - WR_BYTE: after 8 bits go to WR_ACK.
    - RX not full: push the byte and ACK.
    - RX full: set rx_overflow, drop the byte, NACK (sda_oe=0).
    - Then return to WR_BYTE.
  - RD_BYTE: drive sda_oe = ~shift[7] per bit. After 8 bits release SDA and go to RD_ACK.
    - The pop occurs when the byte is loaded, not when it is acknowledged.
    - TX empty at load: send 8'hFF and set tx_underflow.
  - RD_ACK: sample SDA on SCL rise.
    - ACK (0): load the next byte and go to RD_BYTE.
    - NACK (1): go to IGNORE.
- rx_irq is updated every clk with rx_not_empty, giving 1 cycle of latency.
- CPU and I2C pushes/pops on different FIFOs in the same cycle are independent.

Test Plan:
- Reset mid-transfer: assert reset during WR_BYTE bit 4 -> sda_oe=0, STATUS=0x02, next START is decoded normally.
- Master write to 0x42 of bytes 0x5A, 0xC3, then STOP -> both ACKed; rx_irq=1; CPU DATA reads return 0x005A then 0x00C3; STATUS then reads 0x02.
- Master write of 9 bytes with no CPU reads (depth 8) -> bytes 1-8 ACKed, 9th NACKed; STATUS bit2=1; a second STATUS read shows bit2=0; RX holds bytes 1-8 in order.
- CPU writes 0x11, 0x22; master reads 3 bytes (ACK, ACK, NACK) -> SDA shows 0x11, 0x22, 0xFF; tx_underflow=1; FSM enters IGNORE.
- Address 0x43 write, then STOP -> no ACK, sda_oe stays 0 throughout, FIFOs unchanged; a following transfer to 0x42 succeeds.
- Repeated START after 3 data bits of a write -> partial byte discarded, RX count unchanged, new address phase ACKed; simultaneous CPU pop and I2C push on a full RX -> count stays 8, no overflow.
